wire_response_checker: RTL and testbench

- Hardware-side checker for the single-wire stimulus/response interface.
- A stimulus source drives stim_a; this block samples the block-under-test responses resp_b and resp_c and checks them against a delayed model:
  - resp_b must equal stim_a.
  - resp_c must equal ~stim_a.
- It counts stimulus toggles and mismatches, then reports pass/fail after a fixed number of toggles.
- It closes the loop at the receiving end of the wire-test flow, so a run needs no simulator-side waveform inspection.

---
 rtl/wire_response_checker.sv | 128 ++++++++++++
 tb/tb_wire_response_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wire_response_checker.sv
// Checks single-wire responses (resp_b == stim_a, resp_c == ~stim_a) against a LAT-cycle delayed
// model of stim_a and reports pass/fail after EXP_TOGGLES toggles. Optional: WIRE_CHK_TIMEOUT_EN.
module wire_response_checker #(
  parameter int unsigned LAT         = 0,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned EXP_TOGGLES = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stim_a,
  input  logic             resp_b,
  input  logic             resp_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_flag,
  output logic             timeout,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned ARM_LEN = (LAT == 0) ? 1 : LAT;

  typedef enum logic [2:0] {IDLE, ARM, CHECK, DRAIN, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] phase_cnt;
  logic       a_exp, prev_a, toggle, mismatch, launch, idle_hit;

  if (LAT > 7 || EXP_TOGGLES == 0 || TIMEOUT == 0) begin : g_bad_cfg
    $error("wire_response_checker: parameter out of range");
  end

  if (LAT == 0) begin : g_no_dly
    assign a_exp = stim_a;
  end else begin : g_dly
    logic [LAT-1:0] dly;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dly <= '0;
      else        dly <= LAT'({dly, stim_a});
    end
    assign a_exp = dly[LAT-1];
  end

  assign toggle   = stim_a ^ prev_a;
  assign mismatch = (resp_b != a_exp) || (resp_c != ~a_exp);
  assign launch   = ((state == IDLE) || (state == DONE)) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = ARM;
      ARM:        if (phase_cnt == 4'(ARM_LEN - 1)) state_nxt = CHECK;
      CHECK: begin
        if (toggle && (toggle_cnt == CNT_W'(EXP_TOGGLES - 1))) state_nxt = DRAIN;
        else if (idle_hit)                                      state_nxt = DONE;
      end
      DRAIN:      if (phase_cnt == 4'(LAT)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // phase_cnt times both the ARM fill and the DRAIN tail; restarts on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   phase_cnt <= '0;
    else if (state_nxt != state)                  phase_cnt <= '0;
    else if ((state == ARM) || (state == DRAIN))  phase_cnt <= phase_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_a     <= 1'b0;
      toggle_cnt <= '0;
      err_cnt    <= '0;
      err_flag   <= 1'b0;
    end else begin
      prev_a <= stim_a;
      if (launch) begin
        toggle_cnt <= '0;
        err_cnt    <= '0;
        err_flag   <= 1'b0;
      end else if ((state == CHECK) || (state == DRAIN)) begin
        if (mismatch) begin
          err_flag <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
        if ((state == CHECK) && toggle) toggle_cnt <= toggle_cnt + 1'b1;
      end
    end
  end

`ifdef WIRE_CHK_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] idle_cnt;

  assign idle_hit = (state == CHECK) && !toggle && (idle_cnt == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (launch) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (state == CHECK) begin
      if (toggle)        idle_cnt <= '0;
      else if (idle_hit) timeout  <= 1'b1;
      else               idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign idle_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign busy = (state == ARM) || (state == CHECK) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0) && !timeout;

endmodule

// File: tb/tb_wire_response_checker.sv
// Randomized bench for wire_response_checker: two instances (LAT=0/CNT_W=8, LAT=2/CNT_W=4) share
// the stimulus; a per-run reference scans recorded wire history to predict the run outcome.
module tb_wire_response_checker;
  localparam int MAXC = 4096;
`ifdef WIRE_CHK_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start, stim_a, r0_b, r0_c, r2_b, r2_c;
  logic       busy0, done0, pass0, ef0, to0;
  logic       busy2, done2, pass2, ef2, to2;
  logic [7:0] tc0, ec0;
  logic [3:0] tc2, ec2;

  int vectors = 0, miscompares = 0, cyc = 0, last_edge = 0, dly2 = 2;
  bit fault_en = 1'b0, c_stuck = 1'b0, cur_a = 1'b0;
  bit s_h[MAXC], b0_h[MAXC], c0_h[MAXC], b2_h[MAXC], c2_h[MAXC], od0[MAXC], od2[MAXC];

  always #5 clk = ~clk;

  wire_response_checker #(.LAT(0), .CNT_W(8), .EXP_TOGGLES(4), .TIMEOUT(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stim_a(stim_a), .resp_b(r0_b), .resp_c(r0_c),
    .busy(busy0), .done(done0), .pass(pass0), .err_flag(ef0), .timeout(to0),
    .toggle_cnt(tc0), .err_cnt(ec0));

  wire_response_checker #(.LAT(2), .CNT_W(4), .EXP_TOGGLES(4), .TIMEOUT(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stim_a(stim_a), .resp_b(r2_b), .resp_c(r2_c),
    .busy(busy2), .done(done2), .pass(pass2), .err_flag(ef2), .timeout(to2),
    .toggle_cnt(tc2), .err_cnt(ec2));

  // Wire history as seen at each rising edge; reset zeroes the checker's view of stim_a.
  always @(posedge clk) begin
    if (cyc >= MAXC - 1) begin
      $display("FAIL cycle_budget observed=%0d required<%0d", cyc, MAXC - 1);
      $fatal(1);
    end
    s_h[cyc]  = rst_n & stim_a;
    b0_h[cyc] = r0_b;  c0_h[cyc] = r0_c;
    b2_h[cyc] = r2_b;  c2_h[cyc] = r2_c;
    cyc++;
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input bit st);
    bit f, d;
    @(negedge clk);
    if (cyc > 0) begin od0[cyc-1] = done0; od2[cyc-1] = done2; end
    last_edge = cyc;
    start  = st;
    stim_a = cur_a;
    f = fault_en && ($urandom_range(15, 0) == 0);  r0_b = cur_a ^ f;
    f = fault_en && ($urandom_range(15, 0) == 0);  r0_c = c_stuck ? 1'b0 : (~cur_a ^ f);
    d = (cyc >= dly2) ? s_h[cyc-dly2] : 1'b0;
    f = fault_en && ($urandom_range(15, 0) == 0);  r2_b = d ^ f;
    f = fault_en && ($urandom_range(15, 0) == 0);  r2_c = c_stuck ? 1'b0 : (~d ^ f);
  endtask

  // Outcome of a run started at edge k: walk the recorded edges applying the checking rules.
  function automatic void model(input int k, input int w, output int done_at, output int tog,
                                output int err, output bit tmo);
    int lat, maxe, c, idle, left;
    bit drain, ae, rb, rc;
    lat  = (w == 0) ? 0 : 2;
    maxe = (w == 0) ? 255 : 15;
    c    = k + ((lat == 0) ? 1 : lat) + 1;
    idle = 0; left = 0; drain = 1'b0;
    done_at = -1; tog = 0; err = 0; tmo = 1'b0;
    while (c < cyc) begin
      ae = s_h[c-lat];
      rb = (w == 0) ? b0_h[c] : b2_h[c];
      rc = (w == 0) ? c0_h[c] : c2_h[c];
      if (((rb != ae) || (rc == ae)) && (err < maxe)) err++;
      if (drain) begin
        left--;
        if (left == 0) begin done_at = c; return; end
      end else if (s_h[c] != s_h[c-1]) begin
        tog++; idle = 0;
        if (tog == 4) begin drain = 1'b1; left = lat + 1; end
      end else if (TMO_EN) begin
        idle++;
        if (idle == 16) begin tmo = 1'b1; done_at = c; return; end
      end
      c++;
    end
  endfunction

  task automatic evaluate(input int k);
    int da, tg, er;
    bit tm;
    for (int w = 0; w < 2; w++) begin
      model(k, w, da, tg, er, tm);
      if (da >= 0) begin
        chk($sformatf("L%0d_done_rise", 2*w), (w == 0) ? od0[da] : od2[da], 1);
        chk($sformatf("L%0d_done_prev", 2*w), (w == 0) ? od0[da-1] : od2[da-1], 0);
        chk($sformatf("L%0d_done", 2*w), (w == 0) ? done0 : done2, 1);
        chk($sformatf("L%0d_pass", 2*w), (w == 0) ? pass0 : pass2, (er == 0 && !tm) ? 1 : 0);
      end else begin
        chk($sformatf("L%0d_busy", 2*w), (w == 0) ? busy0 : busy2, 1);
        chk($sformatf("L%0d_done", 2*w), (w == 0) ? done0 : done2, 0);
      end
      chk($sformatf("L%0d_toggle_cnt", 2*w), (w == 0) ? int'(tc0) : int'(tc2), tg);
      chk($sformatf("L%0d_err_cnt", 2*w), (w == 0) ? int'(ec0) : int'(ec2), er);
      chk($sformatf("L%0d_err_flag", 2*w), (w == 0) ? ef0 : ef2, (er > 0) ? 1 : 0);
      chk($sformatf("L%0d_timeout", 2*w), (w == 0) ? to0 : to2, tm ? 1 : 0);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy0"}, busy0, 0);   chk({tag, "_busy2"}, busy2, 0);
    chk({tag, "_done0"}, done0, 0);   chk({tag, "_done2"}, done2, 0);
    chk({tag, "_pass0"}, pass0, 0);   chk({tag, "_pass2"}, pass2, 0);
    chk({tag, "_eflag0"}, ef0, 0);    chk({tag, "_eflag2"}, ef2, 0);
    chk({tag, "_tmo0"}, to0, 0);      chk({tag, "_tmo2"}, to2, 0);
    chk({tag, "_tcnt0"}, int'(tc0), 0); chk({tag, "_tcnt2"}, int'(tc2), 0);
    chk({tag, "_ecnt0"}, int'(ec0), 0); chk({tag, "_ecnt2"}, int'(ec2), 0);
  endtask

  task automatic do_run(input int glo, input int ghi, input bit faults, input bit mid_start);
    int k, g;
    fault_en = faults;
    tick(1'b1);
    k = last_edge;
    tick(1'b0);
    chk("arm_busy0", busy0, 1);  chk("arm_busy2", busy2, 1);
    chk("arm_done0", done0, 0);  chk("arm_tcnt0", int'(tc0), 0);  chk("arm_ecnt2", int'(ec2), 0);
    for (int i = 0; i < 4; i++) begin
      g = $urandom_range(ghi, glo);
      for (int j = 0; j < g; j++) tick(mid_start && (i == 1) && (j == 1));
      if (mid_start && (i == 1)) chk("mid_start_busy0", busy0, 1);
      cur_a = ~cur_a;
    end
    repeat (14) tick(1'b0);
    fault_en = 1'b0;
    evaluate(k);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; stim_a = 1'b0;
    r0_b = 1'b0; r0_c = 1'b1; r2_b = 1'b0; r2_c = 1'b1;
    repeat (3) tick(1'b0);
    chk_cleared("reset");
    rst_n = 1'b1;
    repeat (2) tick(1'b0);

    dly2 = 2;
    do_run(20, 20, 1'b0, 1'b0);
    chk("tp1_pass0", pass0, 1); chk("tp1_tcnt0", int'(tc0), 4); chk("tp1_ecnt0", int'(ec0), 0);
    chk("tp1_eflag0", ef0, 0);  chk("tp1_pass2", pass2, 1);     chk("tp1_ecnt2", int'(ec2), 0);

    dly2 = 3;
    do_run(20, 20, 1'b0, 1'b0);
    chk("tp2_pass2", pass2, 0); chk("tp2_ecnt2", int'(ec2), 4); chk("tp2_eflag2", ef2, 1);

    dly2 = 2; c_stuck = 1'b1;
    do_run(20, 20, 1'b0, 1'b0);
    chk("stuck_ecnt2_sat", int'(ec2), 15); chk("stuck_eflag2", ef2, 1); chk("stuck_pass0", pass0, 0);
    c_stuck = 1'b0;

    for (int r = 0; r < 6; r++) begin
      dly2 = $urandom_range(3, 2);
      do_run(3, 15, 1'b1, r < 2);
    end

    dly2 = 2;
    tick(1'b1);
    repeat (2) begin repeat (6) tick(1'b0); cur_a = ~cur_a; end
    repeat (4) tick(1'b0);
    chk("pre_abort_tcnt0", int'(tc0), 2);
    #3 rst_n = 1'b0;
    #1 chk_cleared("async_rst");
    repeat (2) tick(1'b0);
    rst_n = 1'b1;
    tick(1'b0);
    do_run(8, 8, 1'b0, 1'b0);
    chk("post_rst_pass0", pass0, 1); chk("post_rst_pass2", pass2, 1);

    tick(1'b1);
    k = last_edge;
    repeat (5) tick(1'b0);
    cur_a = ~cur_a;
    repeat (30) tick(1'b0);
    evaluate(k);
`ifdef WIRE_CHK_TIMEOUT_EN
    chk("tmo_flag0", to0, 1); chk("tmo_done0", done0, 1); chk("tmo_pass0", pass0, 0);
    chk("tmo_tcnt0", int'(tc0), 1);
`else
    chk("notmo_busy0", busy0, 1); chk("notmo_flag0", to0, 0); chk("notmo_tcnt0", int'(tc0), 1);
`endif
    repeat (3) begin repeat (5) tick(1'b0); cur_a = ~cur_a; end
    repeat (14) tick(1'b0);
    evaluate(k);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
